// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter fed by a small FIFO. Each frame carries its own
//   configuration: data length 5..8, parity none/odd/even, 1 or 2 stop bits
//   and a clocks-per-bit divisor. Queued bytes are sent back-to-back.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_tx_valid/o_tx_ready byte write handshake (o_tx_ready = FIFO not full)
//   i_tx_data             byte to send (bits above the data length ignored)
//   i_data_len            00..11 -> 5..8 data bits
//   i_parity_type         00/11 none, 01 odd, 10 even
//   i_stop_bits           0 one, 1 two stop bits
//   i_baud_div            clocks per bit, values below 2 act as 2
//   o_data_tx             serial line, idles high
//   o_active_flag         high while a frame is in progress
//   o_done_flag           one-cycle pulse on the last cycle of each frame
//   o_fifo_count          entries currently queued
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_tx_valid,
    output logic                          o_tx_ready,
    input  logic [7:0]                    i_tx_data,
    input  logic [1:0]                    i_data_len,
    input  logic [1:0]                    i_parity_type,
    input  logic                          i_stop_bits,
    input  logic [DIV_WIDTH-1:0]          i_baud_div,
    output logic                          o_data_tx,
    output logic                          o_active_flag,
    output logic                          o_done_flag,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    // FIFO storage
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [CW-1:0]        r_count;

    // Frame state, all latched at pop time
    state_t               r_state, w_next;
    logic [7:0]           r_shift;
    logic [2:0]           r_len_m1;
    logic [2:0]           r_bitidx;
    logic                 r_par_en, r_par_bit, r_two_stop;
    logic [DIV_WIDTH-1:0] r_div, r_bitcnt;

    logic                 w_push, w_pop, w_done, w_bit_end, w_not_empty;
    logic [7:0]           w_mask;

    assign w_not_empty   = (r_count != '0);
    // Ready comes from the registered count only; a pop in the same cycle
    // does not open the FIFO until the next cycle.
    assign o_tx_ready    = (r_count != CW'(FIFO_DEPTH));
    assign w_push        = i_tx_valid && o_tx_ready;
    assign w_bit_end     = (r_bitcnt == r_div - 1'b1);
    assign w_mask        = 8'hFF >> (2'd3 - i_data_len);
    assign o_active_flag = (r_state != S_IDLE);
    assign o_done_flag   = w_done;
    assign o_fifo_count  = r_count;

    // Next state, pop request and frame-done pulse
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:   if (w_not_empty) begin
                          w_pop  = 1'b1;
                          w_next = S_START;
                      end
            S_START:  if (w_bit_end) w_next = S_DATA;
            S_DATA:   if (w_bit_end && r_bitidx == r_len_m1)
                          w_next = r_par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (w_bit_end) w_next = S_STOP1;
            S_STOP1, S_STOP2: begin
                if (w_bit_end) begin
                    if (r_state == S_STOP1 && r_two_stop) begin
                        w_next = S_STOP2;
                    end else begin
                        w_done = 1'b1;
                        // Chain straight into the next frame when data waits
                        if (w_not_empty) begin
                            w_pop  = 1'b1;
                            w_next = S_START;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // Line driver decoded from registered state
    always_comb begin
        o_data_tx = 1'b1;
        case (r_state)
            S_START:  o_data_tx = 1'b0;
            S_DATA:   o_data_tx = r_shift[0];
            S_PARITY: o_data_tx = r_par_bit;
            default:  o_data_tx = 1'b1;
        endcase
    end

    // FIFO data array: no reset needed, pointers define validity
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_tx_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_len_m1   <= 3'd7;
            r_bitidx   <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_div      <= DIV_WIDTH'(2);
            r_bitcnt   <= '0;
        end else begin
            r_state <= w_next;

            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_pop) begin
                r_shift    <= r_mem[r_rptr];
                r_len_m1   <= 3'd4 + {1'b0, i_data_len};
                r_par_en   <= (i_parity_type == 2'b01) || (i_parity_type == 2'b10);
                // Even parity bit is the XOR of the enabled bits; odd inverts it
                r_par_bit  <= (^(r_mem[r_rptr] & w_mask)) ^ (i_parity_type == 2'b01);
                r_two_stop <= i_stop_bits;
                r_div      <= (i_baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_baud_div;
                r_bitcnt   <= '0;
                r_bitidx   <= '0;
            end else if (r_state == S_IDLE) begin
                r_bitcnt <= '0;
            end else if (w_bit_end) begin
                r_bitcnt <= '0;
                if (r_state == S_DATA) begin
                    r_shift  <= r_shift >> 1;
                    r_bitidx <= r_bitidx + 1'b1;
                end
            end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo: reset, parity frames, back-to-back
//   queueing with a full FIFO, divisor clamp, mid-frame config change and
//   reset in the middle of a frame.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic [1:0]  data_len;
    logic [1:0]  parity_type;
    logic        stop_bits;
    logic [15:0] baud_div;
    logic        data_tx;
    logic        active_flag;
    logic        done_flag;
    logic [2:0]  fifo_count;

    int n_chk = 0;
    int n_err = 0;
    int stall_cnt;

    uart_tx_fifo #(.FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .i_tx_data     (tx_data),
        .i_data_len    (data_len),
        .i_parity_type (parity_type),
        .i_stop_bits   (stop_bits),
        .i_baud_div    (baud_div),
        .o_data_tx     (data_tx),
        .o_active_flag (active_flag),
        .o_done_flag   (done_flag),
        .o_fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Plain 8N1 frame: start, 8 data LSB first, stop; bit i = i-th bit on line
    function automatic logic [15:0] frame8n1(input logic [7:0] b);
        return {6'b0, 1'b1, b, 1'b0};
    endfunction

    // Single write into a FIFO known to have room; returns just after the edge
    task automatic push(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    // Call any time in the cycle before the frame's first clock. Samples every
    // clock of the frame and checks bit values, bit stability, done position
    // and count, and active_flag.
    task automatic check_frame(input string tag, input logic [15:0] exp_bits,
                               input int nbits, input int div);
        logic [15:0] obs;
        int bad_stable, done_pos, done_cnt, act_bad, i;
        obs = '0; bad_stable = 0; done_pos = 0; done_cnt = 0; act_bad = 0;
        @(posedge clk);
        for (int k = 0; k < nbits * div; k++) begin
            @(negedge clk);
            i = k / div;
            if (k % div == 0) obs[i] = data_tx;
            else if (data_tx !== obs[i]) bad_stable++;
            if (done_flag === 1'b1) begin
                done_cnt++;
                done_pos = k + 1;
            end
            if (active_flag !== 1'b1) act_bad++;
        end
        chk({tag, "_bits"},   obs,        exp_bits);
        chk({tag, "_stable"}, bad_stable, 0);
        chk({tag, "_donepos"}, done_pos,  nbits * div);
        chk({tag, "_donecnt"}, done_cnt,  1);
        chk({tag, "_active"}, act_bad,    0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_line"},   data_tx,     1);
        chk({tag, "_active"}, active_flag, 0);
        chk({tag, "_count"},  fifo_count,  0);
    endtask

    logic [7:0] stream [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h5A};

    initial begin
        rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hAA;
        data_len = 2'b11; parity_type = 2'b00; stop_bits = 1'b0; baud_div = 16'd4;

        // Reset held 3 cycles with valid high: nothing accepted
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_line",   data_tx,     1);
            chk("rst_active", active_flag, 0);
            chk("rst_count",  fifo_count,  0);
            chk("rst_done",   done_flag,   0);
            chk("rst_ready",  tx_ready,    1);
        end
        rst = 1'b0; tx_valid = 1'b0;

        // Odd parity, 8 bits, div 4: 0,1,1,0,1,0,0,1,0,P=1,1
        parity_type = 2'b01;
        push(8'h4B);
        check_frame("odd4B", 16'h0696, 11, 4);
        check_idle("odd4B_end");

        // Even parity, 5 bits, 2 stop; upper bits set to prove they are ignored
        data_len = 2'b00; parity_type = 2'b10; stop_bits = 1'b1;
        push(8'hF3);
        check_frame("even13", 16'h01E6, 9, 4);
        check_idle("even13_end");

        // Back-to-back: 6 writes while one frame is in flight. Five fit
        // (one popped at once + four queued); the sixth waits for a pop.
        data_len = 2'b11; parity_type = 2'b00; stop_bits = 1'b0; baud_div = 16'd2;
        fork
            begin
                stall_cnt = 0;
                for (int b = 0; b < 6; b++) begin
                    logic rdy;
                    @(negedge clk);
                    tx_valid = 1'b1;
                    tx_data  = stream[b];
                    rdy = tx_ready;
                    @(posedge clk);
                    while (!rdy && stall_cnt < 200) begin
                        @(negedge clk);
                        rdy = tx_ready;
                        stall_cnt++;
                        @(posedge clk);
                    end
                end
                @(negedge clk);
                tx_valid = 1'b0;
                chk("b2b_stall", stall_cnt, 17);
            end
            begin
                @(negedge clk);
                @(posedge clk);
                for (int f = 0; f < 6; f++)
                    check_frame($sformatf("b2b%0d", f), frame8n1(stream[f]), 10, 2);
            end
        join
        check_idle("b2b_end");

        // Divisor clamp: 0 and 1 both give 2 clocks per bit
        baud_div = 16'd0;
        push(8'h55);
        check_frame("div0", frame8n1(8'h55), 10, 2);
        check_idle("div0_end");
        baud_div = 16'd1;
        push(8'hC3);
        check_frame("div1", frame8n1(8'hC3), 10, 2);
        check_idle("div1_end");

        // Divisor change mid-frame has no effect on the frame in flight
        baud_div = 16'd3;
        push(8'h96);
        fork
            check_frame("divchg", frame8n1(8'h96), 10, 3);
            begin
                repeat (5) @(negedge clk);
                baud_div = 16'd9;
            end
        join
        check_idle("divchg_end");

        // Reset in the middle of DATA with a second byte queued
        baud_div = 16'd4;
        push(8'h00);
        push(8'h00);
        repeat (8) @(negedge clk);
        chk("mid_line_pre",  data_tx,    0);
        chk("mid_count_pre", fifo_count, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_line",   data_tx,     1);
        chk("mid_active", active_flag, 0);
        chk("mid_count",  fifo_count,  0);
        chk("mid_done",   done_flag,   0);
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_after");

        // Clean frame after the abort
        parity_type = 2'b01;
        push(8'h4B);
        check_frame("post_rst", 16'h0696, 11, 4);
        check_idle("post_rst_end");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
